// File: rtl/adrv9009_rsp_pkg.sv
// Shared constants for the ADRV9009 receive-path 16-tap FIR low-pass filter.
package adrv9009_rsp_pkg;

  localparam int unsigned DataW   = 16;
  localparam int unsigned OutW    = 32;
  localparam int unsigned NumTaps = 16;

  // Symmetric Q15 low-pass coefficients; they sum to 32768, so the DC gain is 1.0.
  localparam logic signed [DataW-1:0] Coeffs [NumTaps] = '{
    16'sd128,  -16'sd256, -16'sd512, 16'sd0,
    16'sd1536, 16'sd3072, 16'sd5120, 16'sd7296,
    16'sd7296, 16'sd5120, 16'sd3072, 16'sd1536,
    16'sd0,    -16'sd512, -16'sd256, 16'sd128
  };

endpackage

// File: rtl/rsp_fir_mac.sv
// FIR multiply-accumulate: registers the 16 full-precision tap products and
// presents their combinational sum. The caller registers the sum.
module rsp_fir_mac
  import adrv9009_rsp_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic signed [DataW-1:0] taps_i [NumTaps],
  output logic signed [OutW-1:0]  sum_o
);

  logic signed [OutW-1:0] prod_d [NumTaps];
  logic signed [OutW-1:0] prod_q [NumTaps];
  logic signed [OutW-1:0] sum_d;

  // Full-precision products; 16x16 signed always fits in 32 bits.
  always_comb begin
    for (int k = 0; k < NumTaps; k++) begin
      prod_d[k] = OutW'(taps_i[k]) * OutW'(Coeffs[k]);
    end
  end

  // Product pipeline register (stage 2).
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < NumTaps; k++) begin
        prod_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NumTaps; k++) begin
        prod_q[k] <= prod_d[k];
      end
    end
  end

  // Sum of registered products; worst-case magnitude stays below 2^31, so no guard bits.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NumTaps; k++) begin
      sum_d = sum_d + prod_q[k];
    end
  end

  assign sum_o = sum_d;

endmodule

// File: rtl/adrv9009_rsp.sv
// ADRV9009 receive sample processor: single-rate 16-tap FIR low-pass filter.
// One sample in and one filtered sample out per clock; a sample captured at
// edge n first reaches out after edge n+2.
module adrv9009_rsp
  import adrv9009_rsp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DataW-1:0]  in,
  output logic [OutW-1:0]   out
);

  logic signed [DataW-1:0] tap_q [NumTaps];
  logic signed [OutW-1:0]  sum;
  logic signed [OutW-1:0]  out_q;

  // Tap delay line (stage 1): newest sample in tap 0, oldest in tap 15.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NumTaps; k++) begin
        tap_q[k] <= '0;
      end
    end else begin
      tap_q[0] <= $signed(in);
      for (int k = 1; k < NumTaps; k++) begin
        tap_q[k] <= tap_q[k-1];
      end
    end
  end

  rsp_fir_mac u_mac (
    .clk_i   (clk),
    .reset_i (reset),
    .taps_i  (tap_q),
    .sum_o   (sum)
  );

  // Output register (stage 3).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= sum;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_adrv9009_rsp.sv
// Self-checking bench for adrv9009_rsp: reset, impulse, DC, staircase sine
// and mid-stream reset, with a direct-convolution reference model.
module tb_adrv9009_rsp;

  logic               clk = 1'b0;
  logic               reset;
  logic        [15:0] in;
  logic signed [31:0] out;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int H [16] = '{128, -256, -512, 0, 1536, 3072, 5120, 7296,
                            7296, 5120, 3072, 1536, 0, -512, -256, 128};
  localparam int MaxMag = 1174405120;

  // Inputs captured since reset, newest first; out after a step is sum h[k]*xh[k+2].
  int xh [18];

  adrv9009_rsp dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  always #5 clk = ~clk;

  function automatic int model_out();
    int acc = 0;
    for (int k = 0; k < 16; k++) acc += H[k] * xh[k+2];
    return acc;
  endfunction

  task automatic clear_hist();
    for (int i = 0; i < 18; i++) xh[i] = 0;
  endtask

  // Drive one sample, let the edge capture it, sample out 1 time unit later.
  task automatic step(input int x);
    in = 16'(x);
    @(posedge clk);
    #1;
    for (int i = 17; i > 0; i--) xh[i] = xh[i-1];
    xh[0] = x;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in    = 16'd1000;
    #1;
    n_checks++;
    if (out !== 32'sd0) begin
      n_fail++;
      $display("FAIL reset_initial: got %0d want 0", out);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out !== 32'sd0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %0d want 0", c, out);
      end
    end
    in    = 16'd0;
    reset = 1'b0;
    clear_hist();
  endtask

  task automatic test_impulse();
    step(1);
    n_checks++;
    if (out !== 32'sd0) begin
      n_fail++;
      $display("FAIL impulse_lat0: got %0d want 0", out);
    end
    step(0);
    n_checks++;
    if (out !== 32'sd0) begin
      n_fail++;
      $display("FAIL impulse_lat1: got %0d want 0", out);
    end
    for (int k = 0; k < 17; k++) begin
      int want;
      want = (k < 16) ? H[k] : 0;
      step(0);
      n_checks++;
      if (out !== want) begin
        n_fail++;
        $display("FAIL impulse_tap %0d: got %0d want %0d", k, out, want);
      end
    end
  endtask

  task automatic test_dc();
    int lvl  [3] = '{32767, -32768, 23170};
    int want [3] = '{1073709056, -1073741824, 759234560};
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 20; c++) step(lvl[i]);
      n_checks++;
      if (out !== want[i]) begin
        n_fail++;
        $display("FAIL dc level %0d: got %0d want %0d", lvl[i], out, want[i]);
      end
    end
  endtask

  task automatic test_sine();
    int lvl [8] = '{0, 23170, 32767, 23170, 0, -23170, -32768, -23170};
    for (int c = 0; c < 176; c++) begin
      int want;
      step(lvl[(c / 10) % 8]);
      want = model_out();
      n_checks++;
      if (out !== want) begin
        n_fail++;
        $display("FAIL sine cycle %0d: got %0d want %0d", c, out, want);
      end
      n_checks++;
      if (out > MaxMag || out < -MaxMag) begin
        n_fail++;
        $display("FAIL sine_bound cycle %0d: got %0d limit %0d", c, out, MaxMag);
      end
    end
  endtask

  task automatic test_midstream_reset();
    for (int c = 0; c < 20; c++) step(23170);
    n_checks++;
    if (out !== 759234560) begin
      n_fail++;
      $display("FAIL mid_pre: got %0d want 759234560", out);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (out !== 32'sd0) begin
      n_fail++;
      $display("FAIL mid_async_clear: got %0d want 0", out);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out !== 32'sd0) begin
      n_fail++;
      $display("FAIL mid_hold: got %0d want 0", out);
    end
    reset = 1'b0;
    clear_hist();
    for (int j = 0; j < 20; j++) begin
      int want;
      step(23170);
      want = model_out();
      n_checks++;
      if (out !== want) begin
        n_fail++;
        $display("FAIL mid_step %0d: got %0d want %0d", j, out, want);
      end
      if (j == 17) begin
        n_checks++;
        if (out !== 759234560) begin
          n_fail++;
          $display("FAIL mid_settle: got %0d want 759234560", out);
        end
      end
    end
  endtask

  initial begin
    clear_hist();
    test_reset();
    test_impulse();
    test_dc();
    test_sine();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adrv9009_rsp.md
ADRV9009_RSP -- requirements
Module: adrv9009_rsp

Interface
REQ-001 Parameters: none; all sizes and coefficients are fixed constants in the shared package.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in  input  16  signed two's-complement receive sample, one new sample per clk cycle.
REQ-005 out  output  32  signed two's-complement filtered sample, registered, one per clk cycle.

Function
REQ-006 The block SHALL implement a single-rate 16-tap FIR low-pass filter, one output per input, no decimation and no handshake.
REQ-007 Coefficients h[0..15] SHALL be signed 16-bit Q15: 128, -256, -512, 0, 1536, 3072, 5120, 7296, 7296, 5120, 3072, 1536, 0, -512, -256, 128.
REQ-008 Coefficient sum SHALL be 32768, giving DC gain 1.0 in Q15, so steady DC input x yields out = x*32768.
REQ-009 Tap delay line: 16 registers of 16 bits; each edge: tap[0] <= in, tap[k] <= tap[k-1] for k = 1..15.
REQ-010 Products tap[k]*h[k] SHALL be full-precision 32-bit signed, registered in pipeline stage 2.
REQ-011 Stage 3 SHALL sum all 16 registered products in 32-bit signed arithmetic and register the result into out.
REQ-012 Latency: a sample captured at edge n SHALL first contribute to out after edge n+2; out after edge n+2 = sum over k of h[k]*x[n-k].
REQ-013 No saturation or rounding SHALL be applied; worst-case magnitude is 32768*35840 = 1,174,405,120 < 2^31, so overflow cannot occur.
REQ-014 Taps not yet written since reset SHALL contribute zero.

Reset
REQ-015 While reset is high, all taps, product registers and out SHALL be 0 immediately, without waiting for clk.
REQ-016 Reset asserted mid-stream SHALL discard all history; after release, out SHALL behave as if the input had been 0 before the first post-reset sample.
REQ-017 The first rising edge with reset low SHALL capture in into tap[0].

Structure
REQ-018 A shared package SHALL hold the data width (16), output width (32), tap count (16) and the coefficient constant array.
REQ-019 The block SHALL contain one natural sub-module, rsp_fir_mac: product registers plus adder tree; the top level SHALL hold the delay line and output register.
REQ-020 The implementation SHALL be fully synchronous to clk, except for the asynchronous reset.

Verification
REQ-021 Reset: hold reset high for 2 cycles with in = 1000 -> out = 0 throughout.
REQ-022 Impulse: in = 1 for one cycle, then 0 -> out runs 128, -256, -512, 0, 1536, 3072, 5120, 7296, 7296, 5120, 3072, 1536, 0, -512, -256, 128, then 0.
   Timing: the first value (128) appears 2 cycles after the impulse is captured.
REQ-023 DC: hold in = 32767 for at least 18 cycles -> out settles at 1,073,709,056.
   Hold in = -32768 -> out settles at -1,073,741,824.
   Hold in = 23170 -> out settles at 759,234,560.
REQ-024 Staircase sine: drive 0, 23170, 32767, 23170, 0, -23170, -32768, -23170, each level held 10 cycles.
   Required response: after the first 96 cycles, out is periodic with period 80 cycles.
   Required response: out never exceeds the limits stated in REQ-013.
REQ-025 Mid-stream reset: pulse reset for 1 cycle during DC input 23170.
   Required response: out = 0 immediately.
   Required response: after release, out then reproduces the full DC step response, reaching 759,234,560 after 18 cycles.
